// File: rtl/fifo_push_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : fifo_arb_pkg
// Brief   : Shared defaults, the counter type and the index-width helper for
//           the fifo_push_arbiter slice.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  localparam int DEF_DRVRS = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Index width that never collapses to zero bits (a single producer still
  // needs a 1-bit index).
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_push_arbiter_if
// Brief     : Producer request/data bus, FIFO push side and debug readback of
//             the push arbiter. master = environment, slave = arbiter.
// Rev       : 1.0  initial release
// ============================================================================
interface fifo_push_arbiter_if #(
  parameter int DRVRS = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  import fifo_arb_pkg::*;

  localparam int IW = clog2_min1(DRVRS);

  logic                   en;
  logic [DRVRS-1:0]       req;
  logic [DRVRS*WIDTH-1:0] dato_in;
  logic [DRVRS-1:0]       ack;
  logic                   push;
  logic [WIDTH-1:0]       dato_out;
  logic                   full;
  logic [IW-1:0]          last_src;
  // One extra bit so that out-of-range selects are representable and read 0.
  logic [IW:0]            stat_sel;
  logic [CNT_W-1:0]       stat_cnt;

  modport master (
    output en, req, dato_in, full, stat_sel,
    input  ack, push, dato_out, last_src, stat_cnt
  );

  modport slave (
    input  en, req, dato_in, full, stat_sel,
    output ack, push, dato_out, last_src, stat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker. Rotates the request vector so
//          that (ptr+1) lands on bit 0, then takes the lowest set bit.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en_i,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [N-1:0] rot;
  int           offs;
  int           idx;

  // Rotate, priority-encode, and map the offset back to a producer index.
  always_comb begin
    rot  = N'({req, req} >> (int'(ptr) + 1));
    offs = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offs = i;
    end
    idx = int'(ptr) + 1 + offs;
    if (idx >= N) idx = idx - N;
    any     = en_i & (|req);
    gnt_idx = IW'(idx);
    gnt     = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_push_arbiter
// Brief  : Round-robin arbiter sharing one FIFO push port among DRVRS
//          producers, with per-producer saturating accept counters.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DRVRS = DEF_DRVRS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  fifo_push_arbiter_if.slave  bus
);

  localparam int IW = clog2_min1(DRVRS);

  logic             gnt_ok;
  logic [DRVRS-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             any;
  logic [IW-1:0]    ptr;
  logic [CNT_W-1:0] cnt [DRVRS];

  // rst in the grant term kills outputs immediately, mid-cycle included.
  assign gnt_ok = bus.en & ~bus.full & ~rst;

  rr_pick #(
    .N  (DRVRS),
    .IW (IW)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .en_i    (gnt_ok),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign bus.ack  = gnt;
  assign bus.push = any;

  // Data mux: forward the winner's data, zero when nothing is pushed.
  always_comb begin
    bus.dato_out = '0;
    if (any) bus.dato_out = bus.dato_in[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  // Pointer and last source follow the winner; both hold without a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= IW'(DRVRS - 1);
      bus.last_src <= '0;
    end else if (any) begin
      ptr          <= gnt_idx;
      bus.last_src <= gnt_idx;
    end
  end

  // Accept counters: bump the winner's count, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DRVRS; i++) cnt[i] <= '0;
    end else if (any) begin
      for (int i = 0; i < DRVRS; i++) begin
        if (gnt_idx == IW'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Stat mux: out-of-range selects read as zero.
  always_comb begin
    bus.stat_cnt = '0;
    if (int'(bus.stat_sel) < DRVRS) bus.stat_cnt = cnt[bus.stat_sel[IW-1:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_push_arbiter
// Brief  : Directed self-checking bench for fifo_push_arbiter with a depth-8
//          FIFO occupancy model driving full.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fifo_push_arbiter_if #(.DRVRS(4), .WIDTH(16), .CNT_W(4)) bif ();

  fifo_push_arbiter #(.DRVRS(4), .WIDTH(16), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Depth-8 FIFO occupancy model (no pops); overflow latches a push into a full FIFO.
  int   fcount = 0;
  logic fifo_clr = 1'b1;
  logic full_force = 1'b0;
  logic overflow = 1'b0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fcount   <= 0;
      overflow <= 1'b0;
    end else if (bif.push) begin
      if (fcount >= 8) overflow <= 1'b1;
      else fcount <= fcount + 1;
    end
  end

  assign bif.full = full_force | (fcount >= 8);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fifo_clr = 1'b1; full_force = 1'b0;
    bif.en = 1'b0; bif.req = '0; bif.stat_sel = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.en = 1'b1; bif.req = 4'b1111;
    #2;
    checks++; if (bif.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bif.ack); end
    checks++; if (bif.push !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", bif.push); end
    checks++; if (bif.dato_out !== 16'h0000) begin failures++; $display("FAIL reset_dato got=%h exp=0000", bif.dato_out); end
    @(negedge clk);
    checks++; if (bif.last_src !== 2'd0) begin failures++; $display("FAIL reset_last_src got=%0d exp=0", bif.last_src); end
    for (int i = 0; i < 4; i++) begin
      bif.stat_sel = 3'(i); #1;
      checks++; if (bif.stat_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt[%0d] got=%0d exp=0", i, bif.stat_cnt); end
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    do_reset();
    bif.en = 1'b1; bif.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #2;
      exp_ack = 4'b0001 << (k % 4);
      checks++; if (bif.ack !== exp_ack) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, bif.ack, exp_ack); end
      checks++; if (bif.push !== 1'b1) begin failures++; $display("FAIL rr_push[%0d] got=%b exp=1", k, bif.push); end
      checks++; if (bif.dato_out !== 16'(16'hA000 + k % 4)) begin failures++; $display("FAIL rr_dato[%0d] got=%h exp=%h", k, bif.dato_out, 16'(16'hA000 + k % 4)); end
      if (k > 0) begin
        checks++; if (bif.last_src !== 2'((k - 1) % 4)) begin failures++; $display("FAIL rr_last_src[%0d] got=%0d exp=%0d", k, bif.last_src, (k - 1) % 4); end
      end
      @(negedge clk);
    end
    #2;
    checks++; if (bif.push !== 1'b0) begin failures++; $display("FAIL rr_full_push got=%b exp=0", bif.push); end
    checks++; if (bif.last_src !== 2'd3) begin failures++; $display("FAIL rr_last_src_end got=%0d exp=3", bif.last_src); end
    for (int i = 0; i < 4; i++) begin
      bif.stat_sel = 3'(i); #1;
      checks++; if (bif.stat_cnt !== 4'd2) begin failures++; $display("FAIL rr_cnt[%0d] got=%0d exp=2", i, bif.stat_cnt); end
    end
    @(negedge clk);
  endtask

  task automatic test_single_to_full();
    do_reset();
    bif.en = 1'b1; bif.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      #2;
      checks++; if (bif.push !== (k < 8)) begin failures++; $display("FAIL single_push[%0d] got=%b exp=%b", k, bif.push, (k < 8)); end
      checks++; if (bif.ack !== ((k < 8) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_ack[%0d] got=%b", k, bif.ack); end
      @(negedge clk);
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL single_overflow got=%b exp=0", overflow); end
    checks++; if (fcount != 8) begin failures++; $display("FAIL single_fcount got=%0d exp=8", fcount); end
    bif.stat_sel = 3'd2; #1;
    checks++; if (bif.stat_cnt !== 4'd8) begin failures++; $display("FAIL single_cnt2 got=%0d exp=8", bif.stat_cnt); end
    checks++; if (bif.last_src !== 2'd2) begin failures++; $display("FAIL single_last_src got=%0d exp=2", bif.last_src); end
  endtask

  task automatic test_full_pulse();
    do_reset();
    bif.en = 1'b1; bif.req = 4'b0011;
    #2;
    checks++; if (bif.ack !== 4'b0001) begin failures++; $display("FAIL fp_pre0 got=%b exp=0001", bif.ack); end
    @(negedge clk); #2;
    checks++; if (bif.ack !== 4'b0010) begin failures++; $display("FAIL fp_pre1 got=%b exp=0010", bif.ack); end
    @(negedge clk);
    bif.req = 4'b1111; full_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (bif.ack !== 4'b0000) begin failures++; $display("FAIL fp_full_ack[%0d] got=%b exp=0000", k, bif.ack); end
      checks++; if (bif.push !== 1'b0) begin failures++; $display("FAIL fp_full_push[%0d] got=%b exp=0", k, bif.push); end
      checks++; if (bif.last_src !== 2'd1) begin failures++; $display("FAIL fp_full_last[%0d] got=%0d exp=1", k, bif.last_src); end
      @(negedge clk);
    end
    full_force = 1'b0;
    #2;
    checks++; if (bif.ack !== 4'b0100) begin failures++; $display("FAIL fp_after0 got=%b exp=0100", bif.ack); end
    @(negedge clk); #2;
    checks++; if (bif.ack !== 4'b1000) begin failures++; $display("FAIL fp_after1 got=%b exp=1000", bif.ack); end
    @(negedge clk); #2;
    checks++; if (bif.ack !== 4'b0001) begin failures++; $display("FAIL fp_after2 got=%b exp=0001", bif.ack); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bif.en = 1'b1; bif.req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++; if (bif.ack !== 4'b0100) begin failures++; $display("FAIL mid_pre_ack got=%b exp=0100", bif.ack); end
    #1; rst = 1'b1; #1;
    checks++; if (bif.ack !== 4'b0000) begin failures++; $display("FAIL mid_ack got=%b exp=0000", bif.ack); end
    checks++; if (bif.push !== 1'b0) begin failures++; $display("FAIL mid_push got=%b exp=0", bif.push); end
    checks++; if (bif.dato_out !== 16'h0000) begin failures++; $display("FAIL mid_dato got=%h exp=0000", bif.dato_out); end
    @(negedge clk);
    bif.en = 1'b0; rst = 1'b0;
    #2;
    checks++; if (bif.last_src !== 2'd0) begin failures++; $display("FAIL mid_last_src got=%0d exp=0", bif.last_src); end
    for (int i = 0; i < 4; i++) begin
      bif.stat_sel = 3'(i); #1;
      checks++; if (bif.stat_cnt !== 4'd0) begin failures++; $display("FAIL mid_cnt[%0d] got=%0d exp=0", i, bif.stat_cnt); end
    end
    bif.en = 1'b1; #1;
    checks++; if (bif.ack !== 4'b0001) begin failures++; $display("FAIL mid_first_ack got=%b exp=0001", bif.ack); end
    checks++; if (bif.dato_out !== 16'hA000) begin failures++; $display("FAIL mid_first_dato got=%h exp=a000", bif.dato_out); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    fifo_clr = 1'b1;
    bif.en = 1'b1; bif.req = 4'b0010;
    repeat (20) @(negedge clk);
    bif.en = 1'b0;
    bif.stat_sel = 3'd1; #2;
    checks++; if (bif.stat_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt1 got=%0d exp=15", bif.stat_cnt); end
    bif.stat_sel = 3'd5; #1;
    checks++; if (bif.stat_cnt !== 4'd0) begin failures++; $display("FAIL sat_sel5 got=%0d exp=0", bif.stat_cnt); end
    bif.stat_sel = 3'd0; #1;
    checks++; if (bif.stat_cnt !== 4'd0) begin failures++; $display("FAIL sat_cnt0 got=%0d exp=0", bif.stat_cnt); end
    @(negedge clk);
    fifo_clr = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    bif.en = 1'b1; bif.req = 4'b0100;
    @(negedge clk);
    bif.en = 1'b0; bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++; if (bif.push !== 1'b0) begin failures++; $display("FAIL en_push[%0d] got=%b exp=0", k, bif.push); end
      checks++; if (bif.last_src !== 2'd2) begin failures++; $display("FAIL en_last[%0d] got=%0d exp=2", k, bif.last_src); end
      @(negedge clk);
    end
    bif.en = 1'b1;
    #2;
    checks++; if (bif.ack !== 4'b1000) begin failures++; $display("FAIL en_resume0 got=%b exp=1000", bif.ack); end
    checks++; if (bif.dato_out !== 16'hA003) begin failures++; $display("FAIL en_resume_dato got=%h exp=a003", bif.dato_out); end
    @(negedge clk); #2;
    checks++; if (bif.ack !== 4'b0001) begin failures++; $display("FAIL en_resume1 got=%b exp=0001", bif.ack); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.en = 1'b0; bif.req = '0; bif.stat_sel = '0;
    for (int i = 0; i < 4; i++) bif.dato_in[i*16 +: 16] = 16'(16'hA000 + i);
    test_reset();
    test_round_robin();
    test_single_to_full();
    test_full_pulse();
    test_reset_mid_burst();
    test_saturation();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
